// File: rtl/arthas_dfsm_pkg.sv
// arthas_dfsm_pkg
// Shared definitions for the dataflow FSM and its upstream issuer.
// This package owns the config word layout {mode, nPeriod, nLMAC, nSHFT}
// (MSB first), so the issuer and the dataflow FSM always agree on it.
package arthas_dfsm_pkg;

  localparam int MAX_nPERIOD  = 8;
  localparam int MAX_nLMAC    = 12288;  // 3 * 512 * 8
  localparam int MAX_nSHFT    = 192;
  localparam int DRAIN_GUARD  = 2;      // idle cycles appended to each shift window

  localparam int PW           = $clog2(MAX_nPERIOD);
  localparam int LW           = $clog2(MAX_nLMAC);
  localparam int SW           = $clog2(MAX_nSHFT);
  localparam int CONF_REG_LEN = 1 + PW + LW + SW;

  localparam logic MD_CONV = 1'b0;
  localparam logic MD_MM   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_START = 3'd2,
    ST_FEED  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } issuer_state_e;

  function automatic logic [CONF_REG_LEN-1:0] pack_cfg(
    input logic          mode,
    input logic [PW-1:0] n_period,
    input logic [LW-1:0] n_lmac,
    input logic [SW-1:0] n_shft
  );
    return {mode, n_period, n_lmac, n_shft};
  endfunction

endpackage

// File: rtl/dfsm_issuer_cnt.sv
// issuer_cnt
// Loadable up-counter with a terminal-match flag. Load has priority over
// increment, so a counter can be cleared on the same cycle it reaches its
// terminal value.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   ld       : load ld_val this cycle
//   ld_val   : value to load
//   inc      : increment by one this cycle
//   term     : terminal value to match against
//   cnt      : current count
//   match    : cnt == term
module issuer_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign match = (cnt == term);

endmodule

// File: rtl/dfsm_issuer.sv
// dfsm_issuer
// Upstream sequencer for the dataflow FSM. Takes one layer command at a
// time, publishes the packed config word, fires a one-cycle start, then per
// period passes exactly nLMAC operand beats (in_en) followed by an idle
// window of nSHFT + DRAIN_GUARD cycles. After nPeriod periods it pulses done.
// Build option: define DFSM_ISSUER_PERF_EN to enable the stall_cycles
// counter (FEED cycles with no operand available); otherwise it reads 0.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   cmd_valid/ready  : command handshake (ready only when idle)
//   cmd_mode         : 0 = CONV, 1 = MM
//   cmd_nPeriod/nLMAC/nSHFT : period count, beats per period, shift cycles
//   src_valid/ready  : upstream operand source handshake
//   config_bits      : {mode, nPeriod, nLMAC, nSHFT} to the dataflow FSM
//   start            : one-cycle start pulse
//   in_en            : operand beat valid to the dataflow FSM
//   busy, done, err  : job in progress, job-end pulse, reject pulse
//   stall_cycles     : saturating stall counter (optional)
module dfsm_issuer
  import arthas_dfsm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_mode,
  input  logic [PW-1:0]           cmd_nPeriod,
  input  logic [LW-1:0]           cmd_nLMAC,
  input  logic [SW-1:0]           cmd_nSHFT,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic [CONF_REG_LEN-1:0] config_bits,
  output logic                    start,
  output logic                    in_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             stall_cycles
);

  issuer_state_e state, state_nxt;

  logic          mode_q;
  logic [PW-1:0] nper_q;
  logic [LW-1:0] nlmac_q;
  logic [SW-1:0] nshft_q;
  logic [PW-1:0] period_cnt;
  logic          err_q;

  logic          accept;
  logic          cmd_zero;
  logic          cmd_ok;
  logic          beat_fire;
  logic          beat_last;
  logic          drain_on;
  logic          drain_last;
  logic          more_periods;
  logic [LW-1:0] beat_cnt;
  logic [LW-1:0] beat_term;
  logic [SW+1:0] drain_cnt;
  logic [SW+1:0] drain_term;

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign cmd_zero  = (cmd_nPeriod == '0) || (cmd_nLMAC == '0) || (cmd_nSHFT == '0);
  assign cmd_ok    = accept && !cmd_zero;
  assign beat_fire = (state == ST_FEED) && src_valid;
  assign drain_on  = (state == ST_DRAIN);

  // Terminal values are computed from the registered, non-zero fields, so
  // the minus-one never underflows. drain_cnt is two bits wider than nSHFT
  // so nSHFT + DRAIN_GUARD - 1 fits even at the largest nSHFT.
  assign beat_term    = nlmac_q - LW'(1);
  assign drain_term   = {2'b00, nshft_q} + (SW+2)'(DRAIN_GUARD - 1);
  assign more_periods = (period_cnt < (nper_q - PW'(1)));

  issuer_cnt #(.W(LW)) u_beat_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (accept || (beat_fire && beat_last)),
    .ld_val ('0),
    .inc    (beat_fire),
    .term   (beat_term),
    .cnt    (beat_cnt),
    .match  (beat_last)
  );

  issuer_cnt #(.W(SW+2)) u_drain_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (accept || (drain_on && drain_last)),
    .ld_val ('0),
    .inc    (drain_on),
    .term   (drain_term),
    .cnt    (drain_cnt),
    .match  (drain_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= 1'b0;
      nper_q     <= '0;
      nlmac_q    <= '0;
      nshft_q    <= '0;
      period_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= accept && cmd_zero;
      // A rejected command leaves the published config untouched.
      if (cmd_ok) begin
        mode_q  <= cmd_mode;
        nper_q  <= cmd_nPeriod;
        nlmac_q <= cmd_nLMAC;
        nshft_q <= cmd_nSHFT;
      end
      if (accept) begin
        period_cnt <= '0;
      end else if (drain_on && drain_last && more_periods) begin
        period_cnt <= period_cnt + PW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    start     = 1'b0;
    in_en     = 1'b0;
    src_ready = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_ok) state_nxt = ST_CFG;
      end
      ST_CFG: begin
        busy      = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: begin
        busy      = 1'b1;
        start     = 1'b1;
        state_nxt = ST_FEED;
      end
      ST_FEED: begin
        busy      = 1'b1;
        in_en     = src_valid;
        src_ready = src_valid;
        if (beat_fire && beat_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_nxt = more_periods ? ST_FEED : ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign config_bits = pack_cfg(mode_q, nper_q, nlmac_q, nshft_q);
  assign err         = err_q;

`ifdef DFSM_ISSUER_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state == ST_FEED) && !src_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dfsm_issuer.sv
`timescale 1ns/1ps
module tb_dfsm_issuer;
  import arthas_dfsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mode;
  logic [2:0]  cmd_nPeriod;
  logic [13:0] cmd_nLMAC;
  logic [7:0]  cmd_nSHFT;
  logic        src_valid;
  logic        src_ready;
  logic [25:0] config_bits;
  logic        start;
  logic        in_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  dfsm_issuer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_nPeriod  (cmd_nPeriod),
    .cmd_nLMAC    (cmd_nLMAC),
    .cmd_nSHFT    (cmd_nSHFT),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .config_bits  (config_bits),
    .start        (start),
    .in_en        (in_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .stall_cycles (stall_cycles)
  );

  // Model: the job is a queue of per-cycle tokens. A FEED token is only
  // consumed by a cycle that carries an operand beat.
  localparam byte TK_I = 8'd0;  // idle (queue empty)
  localparam byte TK_C = 8'd1;
  localparam byte TK_S = 8'd2;
  localparam byte TK_F = 8'd3;
  localparam byte TK_D = 8'd4;
  localparam byte TK_X = 8'd5;

  byte         q[$];
  logic [31:0] m_cfg;
  logic        m_err;
  int          m_stall;
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          acc_cyc = -1, done_cyc = -1, start_cyc = -1, err_cyc = -1;
  int          beats = 0;
  int          done_cnt = 0;
  int          fc = 0;
  int          sv_mode = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin : mon
    byte  h;
    logic e_in;
    cyc++;
    if (rst) begin
      q.delete();
      m_cfg   = '0;
      m_err   = 1'b0;
      m_stall = 0;
      fc      = 0;
    end
    h    = (q.size() > 0) ? q[0] : TK_I;
    e_in = (h == TK_F) && src_valid;
    chk("cmd_ready",   {31'd0, cmd_ready}, {31'd0, h == TK_I});
    chk("busy",        {31'd0, busy},  {31'd0, (h == TK_C) || (h == TK_S) || (h == TK_F) || (h == TK_D)});
    chk("start",       {31'd0, start}, {31'd0, h == TK_S});
    chk("in_en",       {31'd0, in_en}, {31'd0, e_in});
    chk("src_ready",   {31'd0, src_ready}, {31'd0, e_in});
    chk("done",        {31'd0, done},  {31'd0, h == TK_X});
    chk("err",         {31'd0, err},   {31'd0, m_err});
    chk("config_bits", {6'd0, config_bits}, m_cfg);
`ifdef DFSM_ISSUER_PERF_EN
    chk("stall_cycles", {16'd0, stall_cycles}, m_stall);
`else
    chk("stall_cycles", {16'd0, stall_cycles}, 32'd0);
`endif
    if (done)  begin done_cyc = cyc; done_cnt++; end
    if (start) start_cyc = cyc;
    if (err)   err_cyc = cyc;
    if (in_en) beats++;
    if (!rst) begin
      m_err = 1'b0;
      if (h == TK_F) begin
        fc++;
        if (src_valid) void'(q.pop_front());
        else if (m_stall < 65535) m_stall++;
      end else begin
        fc = 0;
        if (h != TK_I) void'(q.pop_front());
      end
      if (cmd_valid && (h == TK_I)) begin
        acc_cyc = cyc;
        beats   = 0;
        m_stall = 0;
        if ((cmd_nPeriod == 0) || (cmd_nLMAC == 0) || (cmd_nSHFT == 0)) begin
          m_err = 1'b1;
        end else begin
          m_cfg = cmd_mode * 32'h0200_0000 + cmd_nPeriod * 32'h0040_0000
                + cmd_nLMAC * 32'h100 + cmd_nSHFT;
          q.push_back(TK_C);
          q.push_back(TK_S);
          for (int p = 0; p < cmd_nPeriod; p++) begin
            repeat (cmd_nLMAC) q.push_back(TK_F);
            repeat (cmd_nSHFT + 2) q.push_back(TK_D);
          end
          q.push_back(TK_X);
        end
      end
    end
  end

  // Operand source: always ready, alternating (low on every 2nd FEED cycle
  // of a period), or random.
  initial begin
    src_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sv_mode)
        0:       src_valid = 1'b1;
        1:       src_valid = !((q.size() > 0) && (q[0] == TK_F) && (fc % 2 == 1));
        default: src_valid = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic m, input int np, input int nl, input int ns);
    int t = 0;
    while (!cmd_ready && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 1000) chk("send_wait_ready", 32'd0, 32'd1);
    cmd_valid   = 1'b1;
    cmd_mode    = m;
    cmd_nPeriod = np[2:0];
    cmd_nLMAC   = nl[13:0];
    cmd_nSHFT   = ns[7:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (!(cmd_ready && !busy && !done) && t < lim) begin
      @(posedge clk); #1; t++;
    end
    if (t >= lim) chk("wait_idle_timeout", t, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_head(input byte tk, input int lim);
    int t = 0;
    while (!((q.size() > 0) && (q[0] == tk)) && t < lim) begin
      @(posedge clk); #1; t++;
    end
    if (t >= lim) chk("wait_head_timeout", t, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0;
    cmd_nPeriod = '0; cmd_nLMAC = '0; cmd_nSHFT = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_config", {6'd0, config_bits}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic job
    sv_mode = 0;
    send(1'b0, 2, 4, 3);
    wait_idle(200);
    chk("basic_cfg", {6'd0, config_bits}, 32'h0080_0403);
    chk("basic_start_lat", start_cyc - acc_cyc, 32'd2);
    chk("basic_done_lat", done_cyc - acc_cyc, 32'd21);
    chk("basic_beats", beats, 32'd8);

    // Bubbles
    sv_mode = 1;
    send(1'b0, 2, 4, 3);
    wait_idle(200);
    chk("bubble_done_lat", done_cyc - acc_cyc, 32'd27);
    chk("bubble_beats", beats, 32'd8);
`ifdef DFSM_ISSUER_PERF_EN
    chk("bubble_stall", {16'd0, stall_cycles}, 32'd6);
`else
    chk("bubble_stall", {16'd0, stall_cycles}, 32'd0);
`endif
    sv_mode = 0;

    // Zero fields
    send(1'b1, 3, 0, 5);
    wait_idle(20);
    chk("zero_err_lat", err_cyc - acc_cyc, 32'd1);
    chk("zero_cfg_kept", {6'd0, config_bits}, 32'h0080_0403);
    chk("zero_no_start", {31'd0, start_cyc < acc_cyc}, 32'd1);
    chk("zero_ready", {31'd0, cmd_ready}, 32'd1);
    send(1'b0, 0, 4, 3);
    wait_idle(20);
    chk("zero_np_err_lat", err_cyc - acc_cyc, 32'd1);
    send(1'b0, 2, 4, 0);
    wait_idle(20);
    chk("zero_ns_err_lat", err_cyc - acc_cyc, 32'd1);
    chk("zero_ns_cfg_kept", {6'd0, config_bits}, 32'h0080_0403);

    // Busy reject
    send(1'b0, 3, 6, 4);
    wait_head(TK_F, 20);
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_nPeriod = 3'd1; cmd_nLMAC = 14'd1; cmd_nSHFT = 8'd1;
    for (int i = 0; i < 3; i++) begin
      chk("busy_ready_low", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_idle(200);
    chk("busy_cfg", {6'd0, config_bits}, 32'h00C0_0604);
    chk("busy_done_lat", done_cyc - acc_cyc, 32'd39);
    chk("busy_beats", beats, 32'd18);

    // Async reset in DRAIN
    send(1'b0, 2, 3, 20);
    wait_head(TK_D, 40);
    @(posedge clk); #1;
    done_cnt = 0;
    rst = 1'b1;
    #2;
    chk("arst_in_en", {31'd0, in_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_cfg", {6'd0, config_bits}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("arst_no_done", done_cnt, 32'd0);

    // MM single-beat corner
    send(1'b1, 1, 1, 1);
    wait_idle(50);
    chk("mm_cfg", {6'd0, config_bits}, 32'h0240_0101);
    chk("mm_msb", {31'd0, config_bits[25]}, 32'd1);
    chk("mm_done_lat", done_cyc - acc_cyc, 32'd7);
    chk("mm_beats", beats, 32'd1);

    // Largest encodable counts
    send(1'b1, 7, 5, 2);
    wait_idle(200);
    chk("np7_done_lat", done_cyc - acc_cyc, 32'd66);
    send(1'b0, 2, 16383, 255);
    wait_idle(40000);
    chk("maxl_done_lat", done_cyc - acc_cyc, 32'd33283);
    chk("maxl_beats", beats, 32'd32766);

    // Randomized jobs
    sv_mode = 2;
    for (int j = 0; j < 25; j++) begin
      send($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 12));
      wait_idle(2000);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
